// File: rtl/spi_host_ctrl.sv
// SPI host: serializes an address byte plus cmd_len data bytes MSB first on mosi, gates the peripheral clock, then idles the clock for GAP_CYCLES.
// Latency: first address bit on mosi one cycle after acceptance; cmd_ready returns 8*(len+1)+GAP_CYCLES+1 cycles after acceptance.
// Backpressure: the serial clock never stalls; missing wr_data sends 0x00 and sets err_underflow. Build option: SPI_HOST_READBACK_EN enables miso capture.
module spi_host_ctrl #(
    parameter int GAP_CYCLES = 16,
    parameter int MAX_LEN    = 63
) (
    input  logic                           sclk,
    input  logic                           rstn,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [7:0]                     cmd_addr,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cmd_len,
    input  logic [7:0]                     wr_data,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    output logic                           mosi,
    input  logic                           miso,
    output logic                           sclk_gate_en,
    output logic [7:0]                     rd_data,
    output logic                           rd_valid,
    output logic                           busy,
    output logic                           err_underflow
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        bit_cnt;
    logic [LEN_W-1:0]  byte_cnt;
    logic [7:0]        shift;
    logic [7:0]        gap_cnt;
    logic              shifting;
    logic              last_bit;

    assign shifting = (state == ADDR) || (state == DATA);
    assign last_bit = shifting && (bit_cnt == 3'd0);

    // The bit on the wire is always the top of the shift register, so it is
    // a flop output and drops to 0 with the asynchronous reset.
    assign mosi = shift[7];

    // State register
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one byte per 8 cycles, then a fixed clock-stopped gap
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cmd_valid) state_nxt = ADDR;
            ADDR,
            DATA: if (bit_cnt == 3'd0) state_nxt = (byte_cnt != '0) ? DATA : GAP;
            GAP:  if (gap_cnt == 8'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        wr_ready  = last_bit && (byte_cnt != '0);
    end

    // Shift register, counters, clock gate and sticky underflow flag
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            shift         <= 8'h00;
            bit_cnt       <= 3'd0;
            byte_cnt      <= '0;
            gap_cnt       <= 8'd0;
            sclk_gate_en  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            sclk_gate_en <= (state_nxt == ADDR) || (state_nxt == DATA);
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        shift         <= cmd_addr;
                        byte_cnt      <= cmd_len;
                        bit_cnt       <= 3'd7;
                        err_underflow <= 1'b0;
                    end
                end
                ADDR,
                DATA: begin
                    // Wraps 0 -> 7 at the byte boundary
                    bit_cnt <= bit_cnt - 3'd1;
                    gap_cnt <= 8'(GAP_CYCLES - 1);
                    if (wr_ready) begin
                        // Keep clocking even without data: a stopped clock
                        // would look like end-of-message to the peripheral.
                        shift    <= wr_valid ? wr_data : 8'h00;
                        byte_cnt <= byte_cnt - 1'b1;
                        if (!wr_valid) begin
                            err_underflow <= 1'b1;
                        end
                    end else begin
                        shift <= {shift[6:0], 1'b0};
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                end
                default: begin
                    shift <= 8'h00;
                end
            endcase
        end
    end

`ifdef SPI_HOST_READBACK_EN
    logic [7:0] cap;

    // Capture miso during data bytes only; publish each completed byte
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            cap      <= 8'h00;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (state == DATA) begin
                cap <= {cap[6:0], miso};
                if (bit_cnt == 3'd0) begin
                    rd_data  <= {cap[6:0], miso};
                    rd_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_miso;

    assign unused_miso = miso;
    assign rd_data     = 8'h00;
    assign rd_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_host_ctrl.sv
// Bench for spi_host_ctrl: directed and random messages against a per-cycle expectation model.
// Expected bus activity is derived from the message contents and cycle offset after acceptance.
// Readback expectations apply when SPI_HOST_READBACK_EN is defined.
module tb_spi_host_ctrl;

    localparam int GAP = 16;

    logic       sclk = 1'b0;
    logic       rstn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [5:0] cmd_len = 6'd0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       miso = 1'b0;
    logic       cmd_ready;
    logic       wr_ready;
    logic       mosi;
    logic       sclk_gate_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       err_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_data [64];
    logic       m_vld  [64];
    logic [7:0] m_rd   [64];
    logic       model_err = 1'b0;
    logic [7:0] model_rd  = 8'h00;

    spi_host_ctrl #(.GAP_CYCLES(GAP), .MAX_LEN(63)) dut (
        .sclk          (sclk),
        .rstn          (rstn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .mosi          (mosi),
        .miso          (miso),
        .sclk_gate_en  (sclk_gate_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    always #5 sclk = ~sclk;

    task automatic check1(input string tag, input int n, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s @n=%0d: observed %b expected %b", tag, n, got, exp);
        end
    endtask

    task automatic check8(input string tag, input int n, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s @n=%0d: observed %h expected %h", tag, n, got, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        check1({tag, "_ready"}, 0, cmd_ready, 1'b1);
        check1({tag, "_busy"},  0, busy, 1'b0);
        check1({tag, "_gate"},  0, sclk_gate_en, 1'b0);
        check1({tag, "_mosi"},  0, mosi, 1'b0);
        check1({tag, "_err"},   0, err_underflow, model_err);
        check8({tag, "_rdd"},   0, rd_data, model_rd);
    endtask

    // One message; n counts cycles after the accepting edge. The final
    // (ready) cycle is checked by the next call or the closing idle check,
    // which also makes consecutive calls exactly back-to-back.
    task automatic run_msg(input logic [7:0] addr, input int len, input int abort_n);
        int         last;
        int         idx;
        int         k;
        logic [7:0] b;
        logic       e_mosi;
        logic       e_gate;
        logic       e_wr;
        logic       e_rdv;
        logic       exp_err;
        last    = 9 + 8 * len + GAP;
        exp_err = 1'b0;
        @(negedge sclk);
        idle_check("idle");
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len[5:0];
        wr_valid  = 1'b0;
        miso      = 1'($urandom);
        @(posedge sclk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = 8'($urandom);
        cmd_len   = 6'($urandom);
        for (int n = 1; n < last; n++) begin
            @(negedge sclk);
            e_gate = (n <= 8 + 8 * len);
            idx    = (n - 1) / 8;
            if (idx == 0)
                b = addr;
            else if (idx <= len)
                b = m_vld[6'(idx - 1)] ? m_data[6'(idx - 1)] : 8'h00;
            else
                b = 8'h00;
            e_mosi = e_gate ? b[3'(7 - ((n - 1) % 8))] : 1'b0;
            e_wr   = (n % 8 == 0) && (n <= 8 * len);
            if (n >= 9 && n % 8 == 1 && (n - 9) / 8 < len && !m_vld[6'((n - 9) / 8)])
                exp_err = 1'b1;
            e_rdv = 1'b0;
`ifdef SPI_HOST_READBACK_EN
            if (n >= 17 && n % 8 == 1 && (n - 17) / 8 < len) begin
                e_rdv    = 1'b1;
                model_rd = m_rd[6'((n - 17) / 8)];
            end
`endif
            check1("busy",  n, busy, 1'b1);
            check1("ready", n, cmd_ready, 1'b0);
            check1("gate",  n, sclk_gate_en, e_gate);
            check1("mosi",  n, mosi, e_mosi);
            check1("wr_rdy", n, wr_ready, e_wr);
            check1("err",   n, err_underflow, exp_err);
            check1("rd_vld", n, rd_valid, e_rdv);
            check8("rd_dat", n, rd_data, model_rd);
            if (abort_n == n) begin
                #2 rstn = 1'b0;
                #1;
                model_err = 1'b0;
                model_rd  = 8'h00;
                check1("rst_gate",  n, sclk_gate_en, 1'b0);
                check1("rst_mosi",  n, mosi, 1'b0);
                check1("rst_busy",  n, busy, 1'b0);
                check1("rst_ready", n, cmd_ready, 1'b1);
                check1("rst_wrrdy", n, wr_ready, 1'b0);
                wr_valid = 1'b0;
                @(negedge sclk);
                rstn = 1'b1;
                return;
            end
            k = (n - 1) / 8;
            if (k < len) begin
                wr_data  = m_data[6'(k)];
                wr_valid = m_vld[6'(k)];
            end else begin
                wr_data  = 8'($urandom);
                wr_valid = 1'($urandom);
            end
            if (n >= 9 && n <= 8 + 8 * len)
                miso = m_rd[6'((n - 9) / 8)][3'(7 - ((n - 9) % 8))];
            else
                miso = 1'($urandom);
        end
        model_err = exp_err;
    endtask

    task automatic fill_random(input int len, input int vld_odds);
        for (int i = 0; i < 64; i++) begin
            m_data[i] = 8'($urandom);
            m_rd[i]   = 8'($urandom);
            m_vld[i]  = (i < len) ? ($urandom_range(0, vld_odds) != 0) : 1'b1;
        end
    endtask

    initial begin
        int len;
        fill_random(0, 1);

        // Held in reset
        repeat (2) @(negedge sclk);
        check1("reset_ready", 0, cmd_ready, 1'b1);
        check1("reset_busy",  0, busy, 1'b0);
        check1("reset_gate",  0, sclk_gate_en, 1'b0);
        check1("reset_mosi",  0, mosi, 1'b0);
        check1("reset_err",   0, err_underflow, 1'b0);
        check1("reset_wrrdy", 0, wr_ready, 1'b0);
        check1("reset_rdvld", 0, rd_valid, 1'b0);
        check8("reset_rddat", 0, rd_data, 8'h00);
        rstn = 1'b1;

        // Address-only message
        run_msg(8'h02, 0, 0);

        // Three-byte write, data always valid
        fill_random(3, 1);
        m_data[0] = 8'hA5; m_data[1] = 8'h3C; m_data[2] = 8'hFF;
        m_vld[0] = 1'b1; m_vld[1] = 1'b1; m_vld[2] = 1'b1;
        run_msg(8'h01, 3, 0);

        // Underflow on the second data byte
        fill_random(2, 1);
        m_vld[0] = 1'b1; m_vld[1] = 1'b0;
        run_msg(8'h40, 2, 0);

        // Readback pattern (also clears the sticky underflow)
        fill_random(2, 1);
        m_vld[0] = 1'b1; m_vld[1] = 1'b1;
        m_rd[0] = 8'h5A; m_rd[1] = 8'hC3;
        run_msg(8'h80, 2, 0);

        // Random messages with occasional underflow
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(0, 6);
            fill_random(len, 5);
            run_msg(8'($urandom), len, 0);
        end

        // Maximum length
        fill_random(63, 7);
        run_msg(8'($urandom), 63, 0);

        // Reset during data byte 1, then a normal message
        fill_random(3, 1);
        run_msg(8'hC7, 3, 20);
        fill_random(4, 1);
        run_msg(8'h3E, 4, 0);

        @(negedge sclk);
        idle_check("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_host_ctrl.md
# spi_host_ctrl

Host-side SPI initiator for the PSEC5 digital serial interface: the block that drives the chip's SPI peripheral rather than sits inside it. It serializes an address byte plus a stream of data bytes, MSB first, onto `mosi`, and gates the peripheral clock through `sclk_gate_en`. Each message ends with a clock-stopped gap so the peripheral detects end-of-message and resets its address pointer. With readback compiled in, it deserializes `miso` into per-byte read data. It is used in the FPGA test firmware and in the chip-level testbench as the bus driver.

## Interface
Parameters:
- `GAP_CYCLES`, 16: `sclk` cycles with the gate off after each message; legal range 4..255.
- `MAX_LEN`, 63: maximum data bytes per message; `cmd_len` is 6 bits wide.

Ports:
- `sclk` in 1: free-running reference clock. All state updates on posedge.
- `rstn` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: message request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_addr` in 8: start address, sent as the first byte.
- `cmd_len` in 6: number of data bytes, 0..63. A value of 0 sends an address-only message.
- `wr_data` in 8: next byte to transmit.
- `wr_valid` in 1: `wr_data` is valid.
- `wr_ready` out 1: one-cycle pulse; `wr_data` is consumed on this cycle.
- `mosi` out 1: serial data to the peripheral `serial_in`. Registered.
- `miso` in 1: serial data from the peripheral `serial_out`.
- `sclk_gate_en` out 1: registered. Top level forms `spi_sclk = ~sclk & sclk_gate_en` with an ICG, so the peripheral samples mid-bit.
- `rd_data` out 8: last captured read byte.
- `rd_valid` out 1: one-cycle pulse per captured byte.
- `busy` out 1: high in any state other than IDLE.
- `err_underflow` out 1: sticky. Cleared only by reset or by the next accepted command.

## Operation
- **States:** IDLE, ADDR, DATA, GAP. A 3-bit bit counter runs 7 down to 0. A 6-bit byte counter tracks remaining data bytes.
- **IDLE:**
  - `cmd_ready`=1, `sclk_gate_en`=0, `mosi`=0.
  - On `cmd_valid`: latch `cmd_addr` into the shift register and latch `cmd_len`. Clear `err_underflow`. Go to ADDR with bit counter 7.
- **ADDR and DATA:**
  - Each cycle: `sclk_gate_en`=1 and `mosi`=shift[7], then shift left.
  - At bit counter 0:
    - If bytes remain, assert `wr_ready` and load the next byte.
    - If `wr_valid`=0 at that cycle, load 0x00 and set `err_underflow`. The clock is never stalled, because stopping it would end the message at the peripheral.
    - From ADDR, go to DATA when `cmd_len`>0, otherwise to GAP.
    - From DATA, decrement the byte counter and go to GAP after the last byte.
- **Readback:** in DATA, `miso` is shifted into the capture register on every cycle. After bit counter 0 of each data byte, `rd_data` takes the full byte and `rd_valid` pulses. During ADDR, `miso` is ignored.
- **GAP:** `sclk_gate_en`=0 and `mosi`=0 for `GAP_CYCLES` cycles, then IDLE. Commands are not accepted during GAP.
- **Reset values:**
  - `cmd_ready` comes out of reset at 1, because the block resets into IDLE.
  - All other outputs reset to 0: `mosi`, `sclk_gate_en`, `wr_ready`, `rd_valid`, `rd_data`, `busy`, `err_underflow`.
  - Reset mid-message drops the gate immediately. The peripheral sees this as end-of-message.

## Timing
- Command accepted at posedge T (`cmd_valid && cmd_ready`):
  - T+1: `busy`=1, `sclk_gate_en`=1, `mosi`=`cmd_addr[7]`.
  - Address bits occupy T+1..T+8. Data byte k (0-based) occupies T+9+8k..T+16+8k.
- `wr_ready` for data byte k pulses at T+8+8k.
- `rd_valid` for byte k pulses at T+17+8k.
- GAP starts at T+9+8·len. IDLE is re-entered and `cmd_ready`=1 at T+9+8·len+`GAP_CYCLES`.
- Total message length is 8·(len+1)+`GAP_CYCLES` cycles. Back-to-back commands are spaced by exactly this plus one acceptance cycle.
- `wr_ready`, `rd_valid` and `cmd_ready` are mutually exclusive in time, except that the last `rd_valid` coincides with the first GAP cycle.

## Configuration
- **`SPI_HOST_READBACK_EN` defined:** the `miso` capture register, `rd_data` and `rd_valid` are implemented as above.
- **Not defined:**
  - No capture logic is built; `miso` is unused.
  - `rd_data` is tied to 0x00 and `rd_valid` is tied to 0.
  - All write-path timing is unchanged.

## Test plan
- **Reset:** hold `rstn`=0 -> `cmd_ready`=1; `busy`, `sclk_gate_en`, `mosi` and `err_underflow` all 0.
- **Address-only:** `cmd_addr`=0x02, `cmd_len`=0 -> `mosi` shows 0,0,0,0,0,0,1,0 with gate high for exactly 8 cycles, then gate low for 16 cycles; `cmd_ready` returns at T+25.
- **Three-byte write:** `cmd_addr`=0x01, `cmd_len`=3, `wr_data` 0xA5, 0x3C, 0xFF always valid -> `wr_ready` pulses at T+8, T+16, T+24; `mosi` bytes are 0x01, 0xA5, 0x3C, 0xFF; `err_underflow`=0.
- **Underflow:** `cmd_len`=2 with `wr_valid` low at the second `wr_ready` -> second data byte sent as 0x00; `err_underflow`=1 until the next command is accepted.
- **Readback (`SPI_HOST_READBACK_EN`):** a `miso` model returns 0x5A, 0xC3 during the data bytes, with `cmd_len`=2 -> `rd_valid` pulses at T+17 with 0x5A and at T+25 with 0xC3.
- **Reset mid-message:** assert `rstn`=0 during DATA byte 1 -> `sclk_gate_en` and `mosi` go to 0 asynchronously; after release the block is in IDLE and accepts a new command normally.
